// File: rtl/mandel_pkg.sv
// Shared constants for the Mandelbrot drawing path: frame-store geometry,
// byte-enable encodings and the address-to-lane decode used by pixel writers.
package mandel_pkg;

  localparam int FS_ADDR_W     = 18;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int NBYTE_W       = 4;
  localparam int DATA_W        = 32;

  localparam logic [NBYTE_W-1:0] NBYTE_NONE = 4'b1111;

  // Active-low byte enable for each pixel lane, indexed by addr[1:0]
  localparam logic [NBYTE_W-1:0] LANE_NBYTE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [NBYTE_W-1:0] lane_nbyte(input logic [1:0] lane);
    return LANE_NBYTE[lane];
  endfunction

endpackage

// File: rtl/wc_fifo.sv
// Small first-word-fall-through FIFO holding completed merge words; the head
// entry is always presented combinationally and stays put until popped.
module wc_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 54
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Guard against overflow/underflow even if the caller misbehaves
  assign w_push = push && (r_count != (PW+1)'(DEPTH));
  assign w_pop  = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/pixel_write_combiner.sv
// Merges single-byte pixel writes into whole frame-store words and queues them.
// Define WC_TIMEOUT_FLUSH_EN to flush a partial word after TIMEOUT idle cycles.
module pixel_write_combiner
  import mandel_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = FS_ADDR_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              draw_busy,
  input  logic              de_req,
  output logic              de_ack,
  input  logic [ADDR_W-1:0] de_addr,
  input  logic [3:0]        de_nbyte,
  input  logic [31:0]       de_data,
  output logic              fs_req,
  input  logic              fs_ack,
  output logic [ADDR_W-1:0] fs_addr,
  output logic [3:0]        fs_nbyte,
  output logic [31:0]       fs_data,
  output logic              busy
);

  localparam int ENTRY_W = ADDR_W + 36;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic              r_m_valid;
  logic [ADDR_W-1:0] r_m_addr;
  logic [3:0]        r_m_nbyte;
  logic [31:0]       r_m_data;
  logic              r_busy_prev;

  logic              w_hit;
  logic              w_mfull;
  logic              w_fall;
  logic              w_timeout;
  logic              w_flush;
  logic              w_fifo_full;
  logic              w_evict;
  logic              w_merge;
  logic              w_load;
  logic [31:0]       w_merged_data;
  logic [CW-1:0]     w_count;
  logic [ENTRY_W-1:0] w_head;

  assign w_hit       = r_m_valid && (de_addr == r_m_addr);
  assign w_mfull     = r_m_valid && (r_m_nbyte == 4'b0000);
  assign w_fall      = r_busy_prev && !draw_busy;
  assign w_flush     = w_mfull || w_fall || w_timeout;
  assign w_fifo_full = (w_count == CW'(DEPTH));
  assign w_evict     = r_m_valid && !w_fifo_full && (w_flush || (de_req && !w_hit));
  assign de_ack      = !rst && de_req && (!r_m_valid || w_hit || w_evict);
  // A hit on a word leaving this cycle opens a fresh word instead of merging
  assign w_merge     = de_ack && w_hit && !w_evict;
  assign w_load      = de_ack && !(w_hit && !w_evict);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merged_data[gi*8 +: 8] = de_nbyte[gi] ? r_m_data[gi*8 +: 8] : de_data[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid   <= 1'b0;
      r_m_addr    <= '0;
      r_m_nbyte   <= NBYTE_NONE;
      r_m_data    <= '0;
      r_busy_prev <= 1'b0;
    end else begin
      r_busy_prev <= draw_busy;
      if (w_evict) r_m_valid <= 1'b0;
      if (w_merge) begin
        r_m_nbyte <= r_m_nbyte & de_nbyte;
        r_m_data  <= w_merged_data;
      end
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_addr  <= de_addr;
        r_m_nbyte <= de_nbyte;
        r_m_data  <= de_data;
      end
    end
  end

`ifdef WC_TIMEOUT_FLUSH_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Saturates at TIMEOUT so a stalled eviction keeps requesting a flush
  always_ff @(posedge clk) begin
    if (rst || de_ack || !r_m_valid) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != TW'(TIMEOUT)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = r_m_valid && (r_tmo_cnt == TW'(TIMEOUT));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  wc_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_evict),
    .pop   (fs_req && fs_ack),
    .din   ({r_m_addr, r_m_nbyte, r_m_data}),
    .head  (w_head),
    .count (w_count)
  );

  assign fs_req                      = (w_count != '0);
  assign {fs_addr, fs_nbyte, fs_data} = w_head;
  assign busy                        = r_m_valid || fs_req;

endmodule
